md5_step_ctrl: RTL

//  Sequencer for the MD5 compression datapath. Accepts one 512-bit block request, then drives the

---
 rtl/md5_pkg.sv | 48 ++++
 rtl/md5_step_decode.sv | 25 ++
 rtl/md5_step_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/md5_pkg.sv
// md5_pkg
// Shared definitions for the MD5 step sequencer and its step decoder:
//   state_t      controller states (IDLE, LOAD, RUN, FINAL, DONE)
//   func_t       round-function select (F, G, H, I)
//   SHIFT_TABLE  left-rotate amounts, indexed by {round, step mod 4}
//   msg_index()  message word index g for a given step
// No ports (package).
package md5_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_FINAL,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      FUNC_F = 2'd0,
      FUNC_G = 2'd1,
      FUNC_H = 2'd2,
      FUNC_I = 2'd3
   } func_t;

   localparam logic [5:0] STEP_LAST = 6'd63;

   // Row = round (step[5:4]), column = step[1:0].
   localparam logic [4:0] SHIFT_TABLE [16] = '{
      5'd7, 5'd12, 5'd17, 5'd22,
      5'd5, 5'd9,  5'd14, 5'd20,
      5'd4, 5'd11, 5'd16, 5'd23,
      5'd6, 5'd10, 5'd15, 5'd21
   };

   // All arithmetic is 4-bit, so the mod-16 reduction is the natural truncation.
   // Only step[3:0] matters because 16*k vanishes mod 16 for every multiplier used.
   function automatic logic [3:0] msg_index(input logic [5:0] step);
      logic [3:0] i;
      i = step[3:0];
      case (step[5:4])
         2'd0:    msg_index = i;
         2'd1:    msg_index = 4'd5 * i + 4'd1;
         2'd2:    msg_index = 4'd3 * i + 4'd5;
         default: msg_index = 4'd7 * i;
      endcase
   endfunction

endpackage

// File: rtl/md5_step_decode.sv
// md5_step_decode
// Pure combinational per-step decode for the MD5 round datapath; also used for
// K-constant ROM addressing.
// Ports:
//   step_idx   in   6  current step 0..63
//   func_sel   out  2  round function 0=F 1=G 2=H 3=I
//   msg_idx    out  4  message word index g
//   shift_amt  out  5  left-rotate amount
module md5_step_decode
   import md5_pkg::*;
(
   input  logic [5:0] step_idx,
   output logic [1:0] func_sel,
   output logic [3:0] msg_idx,
   output logic [4:0] shift_amt
);

   func_t func;

   assign func      = func_t'(step_idx[5:4]);
   assign func_sel  = func;
   assign msg_idx   = msg_index(step_idx);
   assign shift_amt = SHIFT_TABLE[{step_idx[5:4], step_idx[1:0]}];

endmodule

// File: rtl/md5_step_ctrl.sv
// md5_step_ctrl
// Sequencer for the MD5 compression datapath: accepts one block, then drives
// load, 64 compression steps and the final chaining add. Holds no hash data.
// Optional feature: define MD5_ABORT_EN to add the abort input.
// Parameters:
//   LOAD_CYCLES   cycles init_load is held (1..4)
//   FINAL_CYCLES  cycles final_add is held (1..4)
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   blk_valid  in   1  block buffer holds a block
//   blk_ready  out  1  block accepted on this edge if valid; IDLE only
//   dp_stall   in   1  datapath hold request, honoured only in RUN
//   abort      in   1  (MD5_ABORT_EN only) abandon the current block
//   init_load  out  1  load A..D from chaining registers
//   step_en    out  1  execute step step_idx this cycle
//   step_idx   out  6  current step 0..63, 0 outside RUN
//   func_sel   out  2  round function select
//   msg_idx    out  4  message word index
//   shift_amt  out  5  rotate amount
//   final_add  out  1  add A..D into chaining registers
//   busy       out  1  not IDLE
//   done       out  1  one-cycle completion pulse
module md5_step_ctrl
   import md5_pkg::*;
#(
   parameter int LOAD_CYCLES  = 1,
   parameter int FINAL_CYCLES = 1
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       blk_valid,
   output logic       blk_ready,
   input  logic       dp_stall,
`ifdef MD5_ABORT_EN
   input  logic       abort,
`endif
   output logic       init_load,
   output logic       step_en,
   output logic [5:0] step_idx,
   output logic [1:0] func_sel,
   output logic [3:0] msg_idx,
   output logic [4:0] shift_amt,
   output logic       final_add,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] LOAD_LAST  = 2'(LOAD_CYCLES - 1);
   localparam logic [1:0] FINAL_LAST = 2'(FINAL_CYCLES - 1);

   state_t     state, state_nx;
   logic [5:0] step_cnt, step_nx;
   logic [1:0] phase, phase_nx;
   logic       abort_req;

`ifdef MD5_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // State, step counter and LOAD/FINAL phase counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         step_cnt <= 6'd0;
         phase    <= 2'd0;
      end else begin
         state    <= state_nx;
         step_cnt <= step_nx;
         phase    <= phase_nx;
      end
   end

   // Next state and strobes. The step counter is cleared on every exit from
   // RUN so step_idx reads 0 in all other states. An aborted RUN cycle does
   // not count as an executed step.
   always_comb begin
      state_nx  = state;
      step_nx   = step_cnt;
      phase_nx  = phase;
      blk_ready = 1'b0;
      init_load = 1'b0;
      step_en   = 1'b0;
      final_add = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            blk_ready = 1'b1;
            if (blk_valid) begin
               state_nx = ST_LOAD;
               phase_nx = 2'd0;
            end
         end
         ST_LOAD: begin
            init_load = 1'b1;
            if (abort_req) begin
               state_nx = ST_IDLE;
               phase_nx = 2'd0;
            end else if (phase == LOAD_LAST) begin
               state_nx = ST_RUN;
               phase_nx = 2'd0;
            end else begin
               phase_nx = phase + 2'd1;
            end
         end
         ST_RUN: begin
            if (abort_req) begin
               state_nx = ST_IDLE;
               step_nx  = 6'd0;
            end else if (!dp_stall) begin
               step_en = 1'b1;
               if (step_cnt == STEP_LAST) begin
                  state_nx = ST_FINAL;
                  step_nx  = 6'd0;
               end else begin
                  step_nx = step_cnt + 6'd1;
               end
            end
         end
         ST_FINAL: begin
            final_add = 1'b1;
            if (abort_req) begin
               state_nx = ST_IDLE;
               phase_nx = 2'd0;
            end else if (phase == FINAL_LAST) begin
               state_nx = ST_DONE;
               phase_nx = 2'd0;
            end else begin
               phase_nx = phase + 2'd1;
            end
         end
         ST_DONE: begin
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
            step_nx  = 6'd0;
            phase_nx = 2'd0;
         end
      endcase
   end

   assign busy     = (state != ST_IDLE);
   assign step_idx = step_cnt;

   md5_step_decode u_decode (
      .step_idx  (step_cnt),
      .func_sel  (func_sel),
      .msg_idx   (msg_idx),
      .shift_amt (shift_amt)
   );

endmodule
